// File: rtl/extmem.sv
// Memory-side responder for the cache external bus: big-endian 64-bit RAM with
// line bursts, byte-lane writes and a console byte strobe.
module extmem #(
  parameter int unsigned AW       = 12,
  parameter int unsigned WAIT     = 0,
  parameter logic [31:0] CONSADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi2,
  input  logic        extreq,
  input  logic        extwr,
  input  logic        extsrc,
  input  logic [31:0] extaddr,
  input  logic [4:0]  extsz,
  input  logic [63:0] extwdata,
  output logic        extrdy,
  output logic        extreply,
  output logic        extreplyto,
  output logic [63:0] extrdata,
  output logic        exterror,
  output logic        consvalid,
  output logic [7:0]  consdata
);

  localparam int unsigned WCW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  logic [63:0]    r_mem [DEPTH];
  state_t         r_state;
  logic [WCW-1:0] r_wcnt;
  logic [AW-1:0]  r_w;
  logic           r_line;
  logic [1:0]     r_last;
  logic [1:0]     r_beat;
  logic           r_err;
  logic           r_zero;

  logic           w_oob;
  logic           w_cons;
  logic           w_err;
  logic [AW-1:0]  w_aw;
  logic [1:0]     w_last;
  logic [1:0]     w_nbeat;
  logic [AW-1:0]  w_baddr;
  logic [63:0]    w_acc_data;
  logic [63:0]    w_first_data;
  logic [63:0]    w_next_data;
  logic           w_we;
  logic [3:0]     w_n;
  logic [6:0]     w_sh;
  logic [63:0]    w_lmask;
  logic [63:0]    w_mask;
  logic [63:0]    w_wd;

  // Request decode
  always_comb begin
    w_oob  = |extaddr[31:AW+3];
    w_cons = (extaddr == CONSADDR);
    w_err  = w_oob && !w_cons;
    w_aw   = extaddr[AW+2:3];
    w_last = 2'd0;
    if (!w_cons) begin
      if (extsz == 5'd31)      w_last = 2'd3;
      else if (extsz == 5'd15) w_last = 2'd1;
    end
    w_acc_data = (w_err || w_cons) ? 64'd0 : r_mem[w_aw];
  end

  // Beat sequencing: dcache lines go critical-word-first, icache lines ascend with wrap
  always_comb begin
    w_nbeat      = r_beat + 2'd1;
    w_baddr      = r_line ? (r_w ^ AW'(w_nbeat)) : (r_w + AW'(w_nbeat));
    w_first_data = r_zero ? 64'd0 : r_mem[r_w];
    w_next_data  = r_zero ? 64'd0 : r_mem[w_baddr];
  end

  // Write lane placement: n bytes right-justified in extwdata land at byte a (MSB first)
  always_comb begin
    w_n     = 4'({1'b0, extsz[2:0]}) + 4'd1;
    w_sh    = {4'd8 - {1'b0, extaddr[2:0]} - w_n, 3'b000};
    w_lmask = ~({64{1'b1}} << {w_n, 3'b000});
    w_mask  = w_lmask << w_sh;
    w_wd    = (extwdata & w_lmask) << w_sh;
    if (extsz == 5'd7 || extsz == 5'd15) begin
      w_mask = {64{1'b1}};
      w_wd   = extwdata;
    end
    w_we = phi2 && (r_state == S_IDLE) && extreq && extwr && !w_oob &&
           (extsz <= 5'd7 || extsz == 5'd15);
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_aw] <= (r_mem[w_aw] & ~w_mask) | (w_wd & w_mask);
  end

  // Responder FSM with registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_w        <= '0;
      r_line     <= 1'b0;
      r_last     <= 2'd0;
      r_beat     <= 2'd0;
      r_err      <= 1'b0;
      r_zero     <= 1'b0;
      extrdy     <= 1'b1;
      extreply   <= 1'b0;
      extreplyto <= 1'b0;
      extrdata   <= 64'd0;
      exterror   <= 1'b0;
      consvalid  <= 1'b0;
      consdata   <= 8'd0;
    end else begin
      consvalid <= 1'b0;
      if (phi2) begin
        case (r_state)
          S_IDLE: begin
            if (extreq && extwr) begin
              if (w_cons) begin
                consvalid <= 1'b1;
                consdata  <= extwdata[7:0];
              end
            end else if (extreq) begin
              r_w        <= w_aw;
              r_line     <= (extsz == 5'd15);
              r_last     <= w_last;
              r_beat     <= 2'd0;
              r_err      <= w_err;
              r_zero     <= w_err || w_cons;
              extreplyto <= extsrc;
              extrdy     <= 1'b0;
              if (WAIT == 0) begin
                r_state  <= S_BEAT;
                extreply <= 1'b1;
                extrdata <= w_acc_data;
                exterror <= w_err;
              end else begin
                r_state <= S_WAIT;
                r_wcnt  <= WCW'(WAIT - 1);
              end
            end
          end
          S_WAIT: begin
            if (r_wcnt == '0) begin
              r_state  <= S_BEAT;
              extreply <= 1'b1;
              extrdata <= w_first_data;
              exterror <= r_err;
            end else begin
              r_wcnt <= r_wcnt - 1'b1;
            end
          end
          S_BEAT: begin
            if (r_beat == r_last) begin
              r_state  <= S_IDLE;
              extreply <= 1'b0;
              extrdy   <= 1'b1;
              extrdata <= 64'd0;
              exterror <= 1'b0;
            end else begin
              r_beat   <= w_nbeat;
              extrdata <= w_next_data;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_extmem.sv
// Directed bench for extmem: one instance with no read latency, one with WAIT=2,
// both driven from the same request bus.
module tb_extmem;

  localparam logic [31:0] CONS = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        phi2 = 1'b1;
  logic        extreq = 1'b0;
  logic        extwr = 1'b0;
  logic        extsrc = 1'b0;
  logic [31:0] extaddr = 32'd0;
  logic [4:0]  extsz = 5'd0;
  logic [63:0] extwdata = 64'd0;

  logic        a_rdy, a_reply, a_to, a_err, a_cv;
  logic [63:0] a_rdata;
  logic [7:0]  a_cd;
  logic        b_rdy, b_reply, b_to, b_err, b_cv;
  logic [63:0] b_rdata;
  logic [7:0]  b_cd;

  int errors = 0;
  int checks = 0;

  extmem #(.AW(12), .WAIT(0), .CONSADDR(CONS)) u_dut (
    .clk(clk), .reset(reset), .phi2(phi2), .extreq(extreq), .extwr(extwr),
    .extsrc(extsrc), .extaddr(extaddr), .extsz(extsz), .extwdata(extwdata),
    .extrdy(a_rdy), .extreply(a_reply), .extreplyto(a_to), .extrdata(a_rdata),
    .exterror(a_err), .consvalid(a_cv), .consdata(a_cd)
  );

  extmem #(.AW(12), .WAIT(2), .CONSADDR(CONS)) u_dut_w (
    .clk(clk), .reset(reset), .phi2(phi2), .extreq(extreq), .extwr(extwr),
    .extsrc(extsrc), .extaddr(extaddr), .extsz(extsz), .extwdata(extwdata),
    .extrdy(b_rdy), .extreply(b_reply), .extreplyto(b_to), .extrdata(b_rdata),
    .exterror(b_err), .consvalid(b_cv), .consdata(b_cd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [4:0] sz, input logic [63:0] d);
    extreq = 1'b1; extwr = 1'b1; extaddr = a; extsz = sz; extwdata = d;
    tick();
    extreq = 1'b0; extwr = 1'b0;
  endtask

  task automatic rd_start(input logic [31:0] a, input logic [4:0] sz, input logic src);
    extreq = 1'b1; extwr = 1'b0; extaddr = a; extsz = sz; extsrc = src;
    tick();
    extreq = 1'b0;
  endtask

  // Single-beat read on the zero-latency instance, then let the WAIT=2 instance drain
  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [63:0] exp, input logic exp_err);
    rd_start(a, 5'd0, 1'b0);
    check({tag, "_reply"}, 64'(a_reply), 64'd1);
    check({tag, "_data"}, a_rdata, exp);
    check({tag, "_err"}, 64'(a_err), 64'(exp_err));
    tick();
    check({tag, "_rdy"}, 64'(a_rdy), 64'd1);
    repeat (4) tick();
  endtask

  logic [63:0] burst [4];
  logic        ea_reply [5];
  logic        ea_rdy   [5];
  logic        eb_reply [5];
  logic        eb_rdy   [5];
  logic [63:0] ea_data  [5];
  logic [63:0] eb_data  [5];

  initial begin
    burst = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    ea_reply = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ea_rdy   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    eb_reply = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    eb_rdy   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ea_data  = '{64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'd0, 64'd0, 64'd0};
    eb_data  = '{64'd0, 64'd0, 64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'd0};

    // Power-on reset
    repeat (4) begin
      tick();
      check("rst_rdy", 64'(a_rdy), 64'd1);
      check("rst_reply", 64'(a_reply), 64'd0);
      check("rst_rdy_w", 64'(b_rdy), 64'd1);
    end
    check("rst_rdata", a_rdata, 64'd0);
    check("rst_to", 64'(a_to), 64'd0);
    check("rst_cv", 64'(a_cv), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) wr(32'h40 + 32'(8 * i), 5'd7, burst[i]);
    wr(32'h10, 5'd7, 64'hA2A2_A2A2_A2A2_A2A2);
    wr(32'h18, 5'd7, 64'hA3A3_A3A3_A3A3_A3A3);
    check("wr_rdy", 64'(a_rdy), 64'd1);

    // icache line burst
    rd_start(32'h40, 5'd31, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("burst_reply", 64'(a_reply), 64'd1);
      check("burst_to", 64'(a_to), 64'd1);
      check("burst_data", a_rdata, burst[k]);
      check("burst_rdy", 64'(a_rdy), 64'd0);
      tick();
    end
    check("burst_end_rdy", 64'(a_rdy), 64'd1);
    check("burst_end_reply", 64'(a_reply), 64'd0);
    repeat (4) tick();

    // dcache line, critical word first, both latencies side by side
    rd_start(32'h18, 5'd15, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("dl_reply", 64'(a_reply), 64'(ea_reply[i]));
      check("dl_rdy", 64'(a_rdy), 64'(ea_rdy[i]));
      if (ea_reply[i]) check("dl_data", a_rdata, ea_data[i]);
      check("dlw_reply", 64'(b_reply), 64'(eb_reply[i]));
      check("dlw_rdy", 64'(b_rdy), 64'(eb_rdy[i]));
      if (eb_reply[i]) check("dlw_data", b_rdata, eb_data[i]);
      tick();
    end

    // Byte-lane writes
    wr(32'h0, 5'd7, 64'd0);
    wr(32'h5, 5'd0, 64'hAB);
    rd_chk("wr_b5", 32'h0, 64'h0000_0000_00AB_0000, 1'b0);
    wr(32'h4, 5'd3, 64'hDEAD_BEEF);
    rd_chk("wr_w4", 32'h0, 64'h0000_0000_DEAD_BEEF, 1'b0);
    wr(32'h0, 5'd7, 64'h0123_4567_89AB_CDEF);
    rd_chk("wr_d0", 32'h0, 64'h0123_4567_89AB_CDEF, 1'b0);

    // Console writes back to back
    extreq = 1'b1; extwr = 1'b1; extaddr = CONS; extsz = 5'd0; extwdata = 64'h41;
    tick();
    check("cons1_v", 64'(a_cv), 64'd1);
    check("cons1_d", 64'(a_cd), 64'h41);
    check("cons1_rdy", 64'(a_rdy), 64'd1);
    extwdata = 64'h42;
    tick();
    check("cons2_v", 64'(a_cv), 64'd1);
    check("cons2_d", 64'(a_cd), 64'h42);
    extreq = 1'b0; extwr = 1'b0;
    tick();
    check("cons_end_v", 64'(a_cv), 64'd0);
    rd_chk("cons_ram", 32'h0, 64'h0123_4567_89AB_CDEF, 1'b0);

    // Out-of-range and console reads
    rd_chk("oob", 32'h8000, 64'd0, 1'b1);
    rd_chk("cons_rd", CONS, 64'd0, 1'b0);

    // No step while phi2 is low
    phi2 = 1'b0;
    extreq = 1'b1; extwr = 1'b0; extaddr = 32'h40; extsz = 5'd0;
    tick();
    check("phi2_rdy", 64'(a_rdy), 64'd1);
    check("phi2_reply", 64'(a_reply), 64'd0);
    phi2 = 1'b1;
    tick();
    extreq = 1'b0;
    check("phi2_go", a_rdata, burst[0]);
    repeat (5) tick();

    // Reset during beat 2 of an icache burst
    rd_start(32'h40, 5'd31, 1'b1);
    tick();
    tick();
    check("mid_beat2", a_rdata, burst[2]);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_reply", 64'(a_reply), 64'd0);
    check("mid_rst_rdy", 64'(a_rdy), 64'd1);
    check("mid_rst_rdata", a_rdata, 64'd0);
    check("mid_rst_rdy_w", 64'(b_rdy), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    rd_chk("post_rst1", 32'h48, burst[1], 1'b0);
    rd_chk("post_rst3", 32'h58, burst[3], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
